// File: rtl/song_sequencer_pkg.sv
// Shared types and defaults for the song sequencer: FSM state encoding and width defaults.
package song_sequencer_pkg;

    localparam int unsigned DEF_SONG_W  = 2;
    localparam int unsigned DEF_IDX_W   = 5;
    localparam int unsigned DEF_NOTE_W  = 6;
    localparam int unsigned DEF_DUR_W   = 6;
    localparam int unsigned DEF_ROM_LAT = 1;
    // Latency counter holds ROM_LAT-1, ROM_LAT is at most 3
    localparam int unsigned LAT_W       = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_WAIT_ROM  = 3'd2,
        ST_ISSUE     = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    function automatic logic is_busy(input state_t s);
        return !(s == ST_IDLE || s == ST_DONE);
    endfunction

endpackage

// File: rtl/song_sequencer_if.sv
// Control, ROM and note-player signals of the song sequencer; master is the sequencer side.
interface song_sequencer_if #(
    parameter int unsigned SONG_W = 2,
    parameter int unsigned IDX_W  = 5,
    parameter int unsigned NOTE_W = 6,
    parameter int unsigned DUR_W  = 6
);
    logic                     play;
    logic                     restart;
    logic                     loop_en;
    logic [SONG_W-1:0]        song;
    logic                     note_done;
    logic [SONG_W+IDX_W-1:0]  rom_addr;
    logic [NOTE_W+DUR_W-1:0]  rom_dout;
    logic [NOTE_W-1:0]        note;
    logic [DUR_W-1:0]         duration;
    logic                     new_note;
    logic                     song_done;
    logic                     busy;

    modport master (
        input  play, restart, loop_en, song, note_done, rom_dout,
        output rom_addr, note, duration, new_note, song_done, busy
    );

    modport slave (
        output play, restart, loop_en, song, note_done, rom_dout,
        input  rom_addr, note, duration, new_note, song_done, busy
    );
endinterface

// File: rtl/song_sequencer_note_index_counter.sv
// Note index register: synchronous clear, saturating increment, terminal-count flag.
module song_sequencer_note_index_counter
    import song_sequencer_pkg::*;
#(
    parameter int unsigned IDX_W = DEF_IDX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_c,
    input  logic             inc_c,
    output logic [IDX_W-1:0] idx,
    output logic             last_c
);

    assign last_c = (idx == {IDX_W{1'b1}});

    // Wrapping to 0 only happens through clr_c, never by overflow
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx <= '0;
        end else if (clr_c) begin
            idx <= '0;
        end else if (inc_c && !last_c) begin
            idx <= idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/song_sequencer.sv
// Song player front end: walks a song's ROM region, issues {note,duration} records
// to the note player one at a time, with pause, restart, loop and end-marker handling.
module song_sequencer
    import song_sequencer_pkg::*;
#(
    parameter int unsigned SONG_W  = DEF_SONG_W,
    parameter int unsigned IDX_W   = DEF_IDX_W,
    parameter int unsigned NOTE_W  = DEF_NOTE_W,
    parameter int unsigned DUR_W   = DEF_DUR_W,
    parameter int unsigned ROM_LAT = DEF_ROM_LAT
) (
    input  logic              clk,
    input  logic              reset,
    song_sequencer_if.master  bus
);

    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic [DUR_W-1:0]  duration;
    } rec_t;

    state_t              state, state_n;
    logic [SONG_W-1:0]   song_q, song_n;
    logic [LAT_W-1:0]    lat_q, lat_n;
    logic [NOTE_W-1:0]   note_q, note_n;
    logic [DUR_W-1:0]    dur_q, dur_n;
    logic                new_note_q, new_note_n;
    logic                song_done_q, song_done_n;
    logic                busy_q;
    logic                idx_clr_c, idx_inc_c, idx_last_c, end_c;
    logic [IDX_W-1:0]    idx;
    rec_t                rec_c;

    assign rec_c = rec_t'(bus.rom_dout);

    song_sequencer_note_index_counter #(.IDX_W(IDX_W)) u_idx (
        .clk    (clk),
        .reset  (reset),
        .clr_c  (idx_clr_c),
        .inc_c  (idx_inc_c),
        .idx    (idx),
        .last_c (idx_last_c)
    );

    // Next-state and next-output logic; end_c funnels both end-of-song paths
    always_comb begin
        state_n     = state;
        song_n      = song_q;
        lat_n       = lat_q;
        note_n      = note_q;
        dur_n       = dur_q;
        new_note_n  = 1'b0;
        song_done_n = 1'b0;
        idx_clr_c   = 1'b0;
        idx_inc_c   = 1'b0;
        end_c       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.play) begin
                    song_n  = bus.song;
                    state_n = ST_FETCH;
                end
            end
            ST_FETCH: begin
                lat_n   = LAT_W'(ROM_LAT - 1);
                state_n = ST_WAIT_ROM;
            end
            ST_WAIT_ROM: begin
                if (lat_q != '0) begin
                    lat_n = lat_q - LAT_W'(1);
                end else if (rec_c.duration == '0) begin
                    end_c = 1'b1;
                end else begin
                    note_n     = rec_c.note;
                    dur_n      = rec_c.duration;
                    new_note_n = 1'b1;
                    state_n    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_n = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (bus.note_done) begin
                    if (idx_last_c) begin
                        end_c = 1'b1;
                    end else begin
                        idx_inc_c = 1'b1;
                        state_n   = bus.play ? ST_FETCH : ST_IDLE;
                    end
                end
            end
            ST_DONE: begin
                if (!bus.play) begin
                    idx_clr_c = 1'b1;
                    state_n   = ST_IDLE;
                end else begin
                    song_done_n = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (end_c) begin
            song_done_n = 1'b1;
            if (bus.loop_en) begin
                idx_clr_c = 1'b1;
                state_n   = bus.play ? ST_FETCH : ST_IDLE;
            end else begin
                state_n = ST_DONE;
            end
        end

        // Restart overrides every other transition
        if (bus.restart) begin
            state_n     = ST_IDLE;
            idx_clr_c   = 1'b1;
            idx_inc_c   = 1'b0;
            song_done_n = 1'b0;
            new_note_n  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            song_q      <= '0;
            lat_q       <= '0;
            note_q      <= '0;
            dur_q       <= '0;
            new_note_q  <= 1'b0;
            song_done_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_n;
            song_q      <= song_n;
            lat_q       <= lat_n;
            note_q      <= note_n;
            dur_q       <= dur_n;
            new_note_q  <= new_note_n;
            song_done_q <= song_done_n;
            busy_q      <= is_busy(state_n);
        end
    end

    assign bus.rom_addr  = {song_q, idx};
    assign bus.note      = note_q;
    assign bus.duration  = dur_q;
    assign bus.new_note  = new_note_q;
    assign bus.song_done = song_done_q;
    assign bus.busy      = busy_q;

endmodule
